// File: rtl/kyber_modmul_pipe.sv
// kyber_modmul_pipe: pipelined WxW unsigned multiplier with Barrett reduction mod Q;
//   per-pair result select: raw product, product mod Q, or running modular MAC.
// Latency: 5 enabled cycles from in_valid sampled to out_valid; one result per enabled cycle.
// Backpressure: none downstream; ce=0 freezes every register (including outputs), clr flushes.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   ce              pipeline enable, 0 stalls all stages
//   clr             synchronous flush of all valids and the accumulator (only while ce=1)
//   in_valid, a, b  operand pair and its valid tag
//   mode            00 raw, 01 modmul, 10 MAC, 11 treated as modmul
//   acc_clr         MAC for this pair starts from 0 instead of acc
//   out_valid, dout result valid and result (modular results zero-extended to 2W)
//   acc             current MAC accumulator
module kyber_modmul_pipe #(
  parameter int W         = 12,
  parameter int Q         = 3329,
  parameter int BARRETT_K = 24,
  parameter int BARRETT_M = 5039
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           clr,
  input  logic           in_valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     mode,
  input  logic           acc_clr,
  output logic           out_valid,
  output logic [2*W-1:0] dout,
  output logic [W-1:0]   acc
);

  localparam int PW = 2 * W;                      // product width
  localparam int MW = $clog2(BARRETT_M + 1);      // Barrett constant width
  localparam int XW = PW + MW;                    // full P*M width, shifted without prior truncation
  localparam int TW = XW - BARRETT_K;             // quotient estimate width
  localparam int RW = W + 1;                      // remainder width, holds values below 2Q

  localparam logic [XW-1:0] M_X = XW'(BARRETT_M);
  localparam logic [RW-1:0] Q_R = RW'(Q);

  localparam logic [1:0] MODE_RAW = 2'b00;
  localparam logic [1:0] MODE_MAC = 2'b10;

  // Stage valids and tags travel together with the data.
  logic          s1_vld, s2_vld, s3_vld, s4_vld;
  logic [W-1:0]  s1_a, s1_b;
  logic [1:0]    s1_mode, s2_mode, s3_mode, s4_mode;
  logic          s1_ac, s2_ac, s3_ac, s4_ac;
  logic [PW-1:0] s2_p, s3_p, s4_p;
  logic [TW-1:0] s3_t;
  logic [RW-1:0] s4_r;

  // S2: full product.
  logic [PW-1:0] p_c;
  assign p_c = {{W{1'b0}}, s1_a} * {{W{1'b0}}, s1_b};

  // S3: quotient estimate T = floor(P*M / 2^K); T is at most one below floor(P/Q).
  logic [XW-1:0] pm_c;
  logic [TW-1:0] t_c;
  assign pm_c = {{MW{1'b0}}, s2_p} * M_X;
  assign t_c  = TW'(pm_c >> BARRETT_K);

  // S4: R = P - T*Q. The true R is below 2Q < 2^(W+1), so only the low W+1 bits
  // of P and T*Q matter; the subtraction wraps correctly modulo 2^(W+1).
  logic [RW-1:0] tq_c;
  logic [RW-1:0] r_c;
  assign tq_c = RW'(s3_t) * Q_R;
  assign r_c  = RW'(s3_p) - tq_c;

  // S5: final conditional subtract, then the MAC add with its own conditional subtract.
  logic [RW-1:0] rm_c;
  logic [RW-1:0] base_c;
  logic [RW-1:0] sum_c;
  logic [RW-1:0] mac_c;
  logic [PW-1:0] res_c;

  assign rm_c   = (s4_r >= Q_R) ? (s4_r - Q_R) : s4_r;
  assign base_c = s4_ac ? '0 : {1'b0, acc};
  assign sum_c  = base_c + rm_c;
  assign mac_c  = (sum_c >= Q_R) ? (sum_c - Q_R) : sum_c;

  always_comb begin
    res_c = PW'(rm_c);
    case (s4_mode)
      MODE_RAW: res_c = s4_p;
      MODE_MAC: res_c = PW'(mac_c);
      default:  res_c = PW'(rm_c);
    endcase
  end

  // Control path: valids, outputs and accumulator are reset and flushable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s3_vld    <= 1'b0;
      s4_vld    <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      acc       <= '0;
    end else if (ce) begin
      if (clr) begin
        // Flush drops everything in flight, including the pair presented now; dout holds.
        s1_vld    <= 1'b0;
        s2_vld    <= 1'b0;
        s3_vld    <= 1'b0;
        s4_vld    <= 1'b0;
        out_valid <= 1'b0;
        acc       <= '0;
      end else begin
        s1_vld    <= in_valid;
        s2_vld    <= s1_vld;
        s3_vld    <= s2_vld;
        s4_vld    <= s3_vld;
        out_valid <= s4_vld;
        // Bubbles leave dout and acc untouched; only MAC entries move acc.
        if (s4_vld) begin
          dout <= res_c;
          if (s4_mode == MODE_MAC) begin
            acc <= W'(mac_c);
          end
        end
      end
    end
  end

  // Data path: qualified by the valids above, so no reset is needed.
  always_ff @(posedge clk) begin
    if (ce) begin
      s1_a    <= a;
      s1_b    <= b;
      s1_mode <= mode;
      s1_ac   <= acc_clr;

      s2_p    <= p_c;
      s2_mode <= s1_mode;
      s2_ac   <= s1_ac;

      s3_p    <= s2_p;
      s3_t    <= t_c;
      s3_mode <= s2_mode;
      s3_ac   <= s2_ac;

      s4_p    <= s3_p;
      s4_r    <= r_c;
      s4_mode <= s3_mode;
      s4_ac   <= s3_ac;
    end
  end

endmodule

// File: tb/tb_kyber_modmul_pipe.sv
// tb_kyber_modmul_pipe: scoreboard bench for kyber_modmul_pipe (default Kyber parameters).
//   Expected results are pushed when a pair is sampled and popped on each new result.
//   Directed scenarios also compare against hand-computed constants.
module tb_kyber_modmul_pipe;
  localparam int W = 12;
  localparam int Q = 3329;

  logic           clk = 1'b0;
  logic           rst_n, ce, clr, in_valid, acc_clr;
  logic [W-1:0]   a, b;
  logic [1:0]     mode;
  logic           out_valid;
  logic [2*W-1:0] dout;
  logic [W-1:0]   acc;

  typedef struct {
    logic [2*W-1:0] dout;
    logic [W-1:0]   acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [W-1:0] macc;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  kyber_modmul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .clr       (clr),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .dout      (dout),
    .acc       (acc)
  );

  // Reference: plain integer arithmetic with %, tracking the accumulator in issue order.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [1:0] mm, input logic mac);
    exp_t        e;
    int unsigned p, r, s;
    p = 32'(ma) * 32'(mb);
    r = p % Q;
    case (mm)
      2'b00:   e.dout = 24'(p);
      2'b10: begin
        s      = (mac ? 0 : 32'(macc)) + r;
        s      = s % Q;
        macc   = 12'(s);
        e.dout = 24'(s);
      end
      default: e.dout = 24'(r);
    endcase
    e.acc = macc;
    return e;
  endfunction

  // Drive one cycle of inputs; ce/clr must already be set for this cycle.
  task automatic put(input logic v, input logic [W-1:0] pa, input logic [W-1:0] pb,
                     input logic [1:0] pm, input logic pac);
    in_valid = v;
    a        = pa;
    b        = pb;
    mode     = pm;
    acc_clr  = pac;
    if (ce && clr) begin
      exp_q.delete();
      macc = '0;
    end else if (ce && v) begin
      exp_q.push_back(model(pa, pb, pm, pac));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout got=%0d want=0", dout); end
    total++; if (acc !== '0) begin bad++; $display("FAIL reset_acc got=%0d want=0", acc); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      put(1'b0, '0, '0, 2'b00, 1'b0);
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b want=0", out_valid); end
    end
  endtask

  task automatic test_raw();
    exp_t e;
    int   seen = -1;
    ce = 1'b1; clr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) put(1'b1, 12'd3328, 12'd3328, 2'b00, 1'b0);
      else        put(1'b0, '0, '0, 2'b00, 1'b0);
      tick();
      if (out_valid === 1'b1) begin
        if (seen < 0) seen = c;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL raw_extra got=result want=none"); end
        else begin
          e = exp_q.pop_front();
          if (dout !== e.dout || acc !== e.acc) begin
            bad++; $display("FAIL raw_model got=%0d/%0d want=%0d/%0d", dout, acc, e.dout, e.acc);
          end
        end
        total++; if (dout !== 24'd11075584) begin bad++; $display("FAIL raw_dout got=%0d want=11075584", dout); end
      end
    end
    total++; if (seen !== 4) begin bad++; $display("FAIL raw_latency got=%0d want=4", seen); end
  endtask

  task automatic test_modmul();
    int   sa[5]   = '{3328, 17, 4095, 0, 3328};
    int   sb[5]   = '{3328, 1729, 4095, 1234, 1};
    int   want[5] = '{1, 2761, 852, 0, 3328};
    int   k = 0;
    exp_t e;
    ce = 1'b1; clr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c < 5) put(1'b1, 12'(sa[c]), 12'(sb[c]), 2'b01, 1'b0);
      else       put(1'b0, '0, '0, 2'b01, 1'b0);
      tick();
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0 || k >= 5) begin bad++; $display("FAIL modmul_extra got=result want=none"); end
        else begin
          e = exp_q.pop_front();
          if (dout !== e.dout || acc !== e.acc) begin
            bad++; $display("FAIL modmul_model got=%0d/%0d want=%0d/%0d", dout, acc, e.dout, e.acc);
          end
          total++; if (dout !== 24'(want[k])) begin bad++; $display("FAIL modmul_dout got=%0d want=%0d", dout, want[k]); end
          total++; if (c !== 4 + k) begin bad++; $display("FAIL modmul_timing got=%0d want=%0d", c, 4 + k); end
        end
        k++;
      end
    end
    total++; if (k !== 5) begin bad++; $display("FAIL modmul_count got=%0d want=5", k); end
  endtask

  task automatic test_mac();
    int   sa[7]   = '{3328, 17, 4095, 2, 17, 2, 17};
    int   sb[7]   = '{3328, 1729, 4095, 3, 1729, 3, 1729};
    int   sm[7]   = '{2, 2, 2, 2, 1, 2, 3};
    int   sac[7]  = '{1, 0, 0, 1, 0, 0, 0};
    int   wd[7]   = '{1, 2762, 285, 6, 2761, 12, 2761};
    int   wacc[7] = '{1, 2762, 285, 6, 6, 12, 12};
    int   k = 0;
    exp_t e;
    ce = 1'b1; clr = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c < 7) put(1'b1, 12'(sa[c]), 12'(sb[c]), 2'(sm[c]), sac[c] != 0);
      else       put(1'b0, '0, '0, 2'b00, 1'b0);
      tick();
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0 || k >= 7) begin bad++; $display("FAIL mac_extra got=result want=none"); end
        else begin
          e = exp_q.pop_front();
          if (dout !== e.dout || acc !== e.acc) begin
            bad++; $display("FAIL mac_model got=%0d/%0d want=%0d/%0d", dout, acc, e.dout, e.acc);
          end
          total++;
          if (dout !== 24'(wd[k]) || acc !== 12'(wacc[k])) begin
            bad++; $display("FAIL mac_seq got=%0d/%0d want=%0d/%0d", dout, acc, wd[k], wacc[k]);
          end
        end
        k++;
      end
    end
    total++; if (k !== 7) begin bad++; $display("FAIL mac_count got=%0d want=7", k); end
  endtask

  task automatic test_stall();
    int   sa[4]   = '{3328, 17, 4095, 5};
    int   sb[4]   = '{3328, 1729, 4095, 7};
    int   want[4] = '{1, 2761, 852, 35};
    int   wc[4]   = '{4, 5, 9, 10};
    int   k = 0;
    int   last = -1;
    exp_t e;
    clr = 1'b0;
    for (int c = 0; c < 14; c++) begin
      ce = !(c >= 6 && c <= 8);
      if (c < 4)       put(1'b1, 12'(sa[c]), 12'(sb[c]), 2'b01, 1'b0);
      else if (!ce)    put(1'b1, 12'd99, 12'd99, 2'b10, 1'b0);
      else             put(1'b0, '0, '0, 2'b01, 1'b0);
      tick();
      if (!ce) begin
        total++;
        if (out_valid !== 1'b1 || dout !== 24'd2761 || acc !== macc) begin
          bad++; $display("FAIL stall_freeze got=%b/%0d/%0d want=1/2761/%0d", out_valid, dout, acc, macc);
        end
      end else if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0 || k >= 4) begin bad++; $display("FAIL stall_extra got=result want=none"); end
        else begin
          e = exp_q.pop_front();
          if (dout !== e.dout || acc !== e.acc) begin
            bad++; $display("FAIL stall_model got=%0d/%0d want=%0d/%0d", dout, acc, e.dout, e.acc);
          end
          total++;
          if (dout !== 24'(want[k]) || c !== wc[k]) begin
            bad++; $display("FAIL stall_order got=%0d@%0d want=%0d@%0d", dout, c, want[k], wc[k]);
          end
        end
        k++;
        last = c;
      end
    end
    ce = 1'b1;
    total++; if (k !== 4) begin bad++; $display("FAIL stall_count got=%0d want=4", k); end
    total++; if (last !== 10) begin bad++; $display("FAIL stall_elapsed got=%0d want=10", last); end
  endtask

  task automatic test_flush();
    ce = 1'b1;
    for (int c = 0; c < 12; c++) begin
      clr = (c == 3);
      if (c < 4) put(1'b1, 12'(100 + c), 12'(200 + c), 2'b10, 1'b0);
      else       put(1'b0, '0, '0, 2'b00, 1'b0);
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0 at %0d", out_valid, c); end
    end
    clr = 1'b0;
    total++; if (acc !== '0) begin bad++; $display("FAIL flush_acc got=%0d want=0", acc); end
    total++; if (dout !== 24'd35) begin bad++; $display("FAIL flush_dout_hold got=%0d want=35", dout); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL flush_queue got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   seen = -1;
    ce = 1'b1; clr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      put(1'b1, 12'd17, 12'd1729, 2'b10, c == 0);
      tick();
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL arst_pre_extra got=result want=none"); end
        else begin
          e = exp_q.pop_front();
          if (dout !== e.dout || acc !== e.acc) begin
            bad++; $display("FAIL arst_pre_model got=%0d/%0d want=%0d/%0d", dout, acc, e.dout, e.acc);
          end
        end
      end
    end
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", out_valid); end
    total++; if (dout !== '0) begin bad++; $display("FAIL arst_dout got=%0d want=0", dout); end
    total++; if (acc !== '0) begin bad++; $display("FAIL arst_acc got=%0d want=0", acc); end
    exp_q.delete();
    macc = '0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) put(1'b1, 12'd17, 12'd1729, 2'b01, 1'b0);
      else        put(1'b0, '0, '0, 2'b00, 1'b0);
      tick();
      if (out_valid === 1'b1) begin
        if (seen < 0) seen = c;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL arst_post_extra got=result want=none"); end
        else begin
          e = exp_q.pop_front();
          if (dout !== e.dout || acc !== e.acc) begin
            bad++; $display("FAIL arst_post_model got=%0d/%0d want=%0d/%0d", dout, acc, e.dout, e.acc);
          end
        end
        total++; if (dout !== 24'd2761) begin bad++; $display("FAIL arst_post_dout got=%0d want=2761", dout); end
      end
    end
    total++; if (seen !== 4) begin bad++; $display("FAIL arst_post_latency got=%0d want=4", seen); end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 10000; i++) begin
      ce  = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 999) < 3);
      put($urandom_range(0, 99) < 75, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
          2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      tick();
      if (ce && out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra got=result want=none at %0d", i); end
        else begin
          e = exp_q.pop_front();
          if (dout !== e.dout || acc !== e.acc) begin
            bad++; $display("FAIL rand_model got=%0d/%0d want=%0d/%0d at %0d", dout, acc, e.dout, e.acc, i);
          end
        end
      end
      if (dut.s4_vld === 1'b1) begin
        total++;
        if (int'(dut.s4_r) >= 2 * Q) begin bad++; $display("FAIL rand_r_bound got=%0d want<%0d", dut.s4_r, 2 * Q); end
      end
    end
    ce = 1'b1; clr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      put(1'b0, '0, '0, 2'b00, 1'b0);
      tick();
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rand_drain_extra got=result want=none"); end
        else begin
          e = exp_q.pop_front();
          if (dout !== e.dout || acc !== e.acc) begin
            bad++; $display("FAIL rand_drain got=%0d/%0d want=%0d/%0d", dout, acc, e.dout, e.acc);
          end
        end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_lost got=%0d pending want=0", exp_q.size()); end
  endtask

  initial begin
    rst_n    = 1'b0;
    ce       = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    mode     = 2'b00;
    acc_clr  = 1'b0;
    macc     = '0;
    test_reset();
    test_raw();
    test_modmul();
    test_mac();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
